// File: rtl/pcie_vc_router.sv
// pcie_vc_router
// Routes words from one input FIFO into NUM_CH virtual-channel FIFOs.
// The channel is selected by the top CH_W bits of each word. Each channel
// has its own pop port and its own popped-word counter.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   init                  enter/stay in INIT; thresholds latched while in INIT
//   umbral_L / umbral_H   almost-empty / almost-full thresholds (latched)
//   push, data_in         write into the input FIFO
//   pop[NUM_CH]           per-channel read request
//   data_out, valid_out   registered per-channel read data and one-cycle strobe
//   almost_full/_empty    per-channel level flags against the latched thresholds
//   in_full               input FIFO holds DEPTH words
//   req, idx              counter read request for channel idx
//   counter_out/_valid    registered counter value and one-cycle strobe
//   state, error_out      FSM state (RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4)
module pcie_vc_router #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 5,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [LVL_W-1:0]         umbral_L,
  input  logic [LVL_W-1:0]         umbral_H,
  input  logic                     push,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_CH-1:0]        pop,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out,
  output logic [NUM_CH-1:0]        almost_full,
  output logic [NUM_CH-1:0]        almost_empty,
  output logic                     in_full,
  input  logic                     req,
  input  logic [CH_W-1:0]          idx,
  output logic [CNT_W-1:0]         counter_out,
  output logic                     counter_valid,
  output logic [2:0]               state,
  output logic                     error_out
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [LVL_W-1:0]  th_l_q, th_h_q;

  // Input FIFO
  logic [DATA_W-1:0] in_mem [DEPTH];
  logic [PTR_W-1:0]  in_wr_q, in_rd_q;
  logic [LVL_W-1:0]  in_lvl_q;

  // Channel FIFOs
  logic [DATA_W-1:0] ch_mem   [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  ch_wr_q  [NUM_CH];
  logic [PTR_W-1:0]  ch_rd_q  [NUM_CH];
  logic [LVL_W-1:0]  ch_lvl_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [DATA_W-1:0] dout_q   [NUM_CH];
  logic [NUM_CH-1:0] valid_q;
  logic [CNT_W-1:0]  cnt_out_q;
  logic              cnt_valid_q;

  // Control decoded from the current state
  logic op_en, cfg_latch;

  logic              in_empty, push_ok, push_err, xfer, all_empty;
  logic [DATA_W-1:0] head;
  logic [CH_W-1:0]   head_ch;
  logic [NUM_CH-1:0] xfer_ch, pop_ok, ch_empty;

  assign in_empty  = (in_lvl_q == '0);
  assign in_full   = (in_lvl_q == LVL_W'(DEPTH));
  assign head      = in_mem[in_rd_q];
  assign head_ch   = head[DATA_W-1 -: CH_W];
  // Full is judged on the pre-edge level, so a push while full is an error
  // even if a transfer frees a slot on the same edge.
  assign push_ok   = op_en && push && !in_full;
  assign push_err  = op_en && push && in_full;
  // Head-of-line blocking: only the head's own channel is ever considered.
  assign xfer      = op_en && !in_empty && !almost_full[head_ch];
  assign all_empty = in_empty && (&ch_empty);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign almost_full[gi]  = (ch_lvl_q[gi] >= th_h_q);
      assign almost_empty[gi] = (ch_lvl_q[gi] <= th_l_q);
      assign ch_empty[gi]     = (ch_lvl_q[gi] == '0);
      assign xfer_ch[gi]      = xfer && (head_ch == CH_W'(gi));
      assign pop_ok[gi]       = op_en && pop[gi] && !ch_empty[gi];
      assign data_out[gi*DATA_W +: DATA_W] = dout_q[gi];
    end
  endgenerate

  assign valid_out     = valid_q;
  assign counter_out   = cnt_out_q;
  assign counter_valid = cnt_valid_q;
  assign state         = state_q;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!init) begin
          if ((th_l_q < th_h_q) && (th_h_q <= LVL_W'(DEPTH))) state_d = ST_IDLE;
          else                                                state_d = ST_ERROR;
        end
      end
      ST_IDLE: begin
        if (push_err)  state_d = ST_ERROR;
        else if (init) state_d = ST_INIT;
        else if (push) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (push_err)                state_d = ST_ERROR;
        else if (all_empty && init)  state_d = ST_INIT;
        else if (all_empty && !push) state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  // FSM: outputs
  always_comb begin
    op_en     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    cfg_latch = (state_q == ST_INIT);
    error_out = (state_q == ST_ERROR);
  end

  // Storage arrays carry no reset; writes are gated by op_en, which is low
  // throughout reset.
  always_ff @(posedge clk) begin
    if (push_ok) in_mem[in_wr_q] <= data_in;
    for (int c = 0; c < NUM_CH; c++) begin
      if (xfer_ch[c]) ch_mem[c][ch_wr_q[c]] <= head;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_l_q      <= '0;
      th_h_q      <= LVL_W'(DEPTH);
      in_wr_q     <= '0;
      in_rd_q     <= '0;
      in_lvl_q    <= '0;
      valid_q     <= '0;
      cnt_out_q   <= '0;
      cnt_valid_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        ch_wr_q[c]  <= '0;
        ch_rd_q[c]  <= '0;
        ch_lvl_q[c] <= '0;
        cnt_q[c]    <= '0;
        dout_q[c]   <= '0;
      end
    end else begin
      if (cfg_latch) begin
        th_l_q <= umbral_L;
        th_h_q <= umbral_H;
      end
      if (push_ok) in_wr_q <= in_wr_q + PTR_W'(1);
      if (xfer)    in_rd_q <= in_rd_q + PTR_W'(1);
      case ({push_ok, xfer})
        2'b10:   in_lvl_q <= in_lvl_q + LVL_W'(1);
        2'b01:   in_lvl_q <= in_lvl_q - LVL_W'(1);
        default: ;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
        if (xfer_ch[c]) ch_wr_q[c] <= ch_wr_q[c] + PTR_W'(1);
        if (pop_ok[c]) begin
          ch_rd_q[c] <= ch_rd_q[c] + PTR_W'(1);
          dout_q[c]  <= ch_mem[c][ch_rd_q[c]];
          cnt_q[c]   <= cnt_q[c] + CNT_W'(1);
        end
        case ({xfer_ch[c], pop_ok[c]})
          2'b10:   ch_lvl_q[c] <= ch_lvl_q[c] + LVL_W'(1);
          2'b01:   ch_lvl_q[c] <= ch_lvl_q[c] - LVL_W'(1);
          default: ;
        endcase
      end
      // pop_ok is already low outside IDLE/ACTIVE, so strobes drop in ERROR.
      valid_q <= pop_ok;
      // Counter snapshot is taken before this edge's increment.
      if (op_en && req) begin
        cnt_out_q   <= cnt_q[idx];
        cnt_valid_q <= 1'b1;
      end else begin
        cnt_valid_q <= 1'b0;
      end
    end
  end

endmodule
